// File: rtl/hit_counter_tx_pkg.sv
// rtl/hit_counter_tx_pkg.sv - shared TX state encoding and frame width helper
package hit_counter_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int frame_w(input int nom_w, input int bit_w);
    return nom_w + bit_w;
  endfunction

endpackage

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - serialiser: start bit, LSB-first payload, stop bit, one-deep pending slot
module frame_tx
  import hit_counter_tx_pkg::*;
#(
  parameter int FRAME_W = 6,
  parameter int DIV     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               snap_valid,
  input  logic [FRAME_W-1:0] snap_data,
  output logic               tx,
  output logic               busy,
  output logic               ovr
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_W - 1);

  tx_state_t          state, state_next;
  logic [CW-1:0]      baud_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] pend_data;
  logic               pend_valid;
  logic               pend_ok;
  logic               baud_done;
  logic               load_slot;
  logic               load_frame;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign pend_ok   = pend_valid & ~clr;

  // A new frame may start from idle or on the very edge the stop bit ends.
  always_comb begin
    state_next = state;
    load_slot  = 1'b0;
    case (state)
      ST_IDLE:  load_slot = 1'b1;
      ST_START: if (baud_done) state_next = ST_DATA;
      ST_DATA:  if (baud_done && bit_cnt == BIT_LAST) state_next = ST_STOP;
      ST_STOP: begin
        if (baud_done) begin
          load_slot  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    load_frame = load_slot & (pend_ok | snap_valid);
    if (load_frame) state_next = ST_START;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      ovr        <= 1'b0;
    end else begin
      if (state == ST_IDLE || baud_done) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;

      if (state != ST_DATA) bit_cnt <= '0;
      else if (baud_done)   bit_cnt <= bit_cnt + 1'b1;

      if (load_frame)                      shreg <= pend_ok ? pend_data : snap_data;
      else if (state == ST_DATA && baud_done) shreg <= shreg >> 1;

      // Pending is consumed first; a snapshot arriving alongside takes its place.
      if (clr) begin
        pend_valid <= 1'b0;
        ovr        <= 1'b0;
      end else if (load_frame && pend_ok) begin
        pend_valid <= snap_valid;
        if (snap_valid) pend_data <= snap_data;
      end else if (snap_valid && !load_frame) begin
        pend_valid <= 1'b1;
        pend_data  <= snap_data;
        if (pend_valid) ovr <= 1'b1;
      end
    end
  end

  assign tx   = (state == ST_START) ? 1'b0 :
                (state == ST_DATA)  ? shreg[0] : 1'b1;
  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/hit_counter_tx.sv
// rtl/hit_counter_tx.sv - hit synchroniser, up/down NOM/BIT counters, LE decode, frame snapshot
module hit_counter_tx
  import hit_counter_tx_pkg::*;
#(
  parameter int NOM_W = 4,
  parameter int BIT_W = 2,
  parameter int DIV   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hit,
  input  logic                  clr,
  input  logic                  dir,
  output logic [NOM_W-1:0]      NOM,
  output logic [BIT_W-1:0]      BIT,
  output logic [(2**BIT_W)-1:0] LE,
  output logic                  TX,
  output logic                  BUSY,
  output logic                  OVR
);

  localparam int FRAME_W = frame_w(NOM_W, BIT_W);
  localparam int LE_W    = 2 ** BIT_W;

  logic sync1, sync2, hist;
  logic vld1, vld2;
  logic hit_event;
  logic snap_valid;

  // History starts high and only tracks the synchroniser once it holds real
  // samples, so a hit already high at reset release is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
      hist  <= 1'b1;
    end else begin
      sync1 <= hit;
      sync2 <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
      hist  <= vld2 ? sync2 : 1'b1;
    end
  end

  assign hit_event = sync2 & ~hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      NOM        <= '0;
      BIT        <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= hit_event & ~clr;
      if (clr) begin
        NOM <= '0;
        BIT <= '0;
      end else if (hit_event) begin
        if (dir) begin
          NOM <= NOM + 1'b1;
          if (&NOM) BIT <= BIT + 1'b1;
        end else begin
          NOM <= NOM - 1'b1;
          if (NOM == '0) BIT <= BIT - 1'b1;
        end
      end
    end
  end

  assign LE = LE_W'(1) << BIT;

  frame_tx #(
    .FRAME_W (FRAME_W),
    .DIV     (DIV)
  ) u_frame_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .snap_valid (snap_valid),
    .snap_data  ({BIT, NOM}),
    .tx         (TX),
    .busy       (BUSY),
    .ovr        (OVR)
  );

endmodule

// File: tb/tb_hit_counter_tx.sv
// tb/tb_hit_counter_tx.sv - scoreboard bench for hit_counter_tx (NOM_W=4, BIT_W=2, DIV=4)
module tb_hit_counter_tx;

  localparam int DIV = 4;
  localparam int FW  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hit = 1'b0;
  logic       clr = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] NOM;
  logic [1:0] BIT;
  logic [3:0] LE;
  logic       TX, BUSY, OVR;

  hit_counter_tx #(.NOM_W(4), .BIT_W(2), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .clr(clr), .dir(dir),
    .NOM(NOM), .BIT(BIT), .LE(LE), .TX(TX), .BUSY(BUSY), .OVR(OVR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int m_nom = 0;
  int m_bit = 0;
  int run = 0;
  int last_run = 0;
  logic [FW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (BUSY === 1'b1) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  // Monitor: decode each frame at mid-bit and compare with the scoreboard head.
  initial begin : monitor
    logic [FW-1:0] got;
    logic [FW-1:0] exp;
    logic          stop_b;
    logic          aborted;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && TX === 1'b0) begin
        aborted = 1'b0;
        repeat (DIV + DIV / 2) @(posedge clk);
        #1;
        for (int i = 0; i < FW; i++) begin
          if (rst_n !== 1'b1) aborted = 1'b1;
          got[i] = TX;
          repeat (DIV) @(posedge clk);
          #1;
        end
        if (rst_n !== 1'b1) aborted = 1'b1;
        stop_b = TX;
        if (!aborted) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got %0h want none", got);
          end else begin
            exp = sb.pop_front();
            if ({stop_b, got} !== {1'b1, exp}) begin
              bad++;
              $display("FAIL frame: got stop=%0b data=%0h want stop=1 data=%0h", stop_b, got, exp);
            end
          end
        end
      end
    end
  end

  task automatic do_hit(input int gap, input bit push);
    @(posedge clk); #1 hit = 1'b1;
    repeat (3) @(posedge clk);
    #1 hit = 1'b0;
    if (!clr) begin
      if (dir) begin
        if (m_nom == 15) m_bit = (m_bit + 1) % 4;
        m_nom = (m_nom + 1) % 16;
      end else begin
        if (m_nom == 0) m_bit = (m_bit + 3) % 4;
        m_nom = (m_nom + 15) % 16;
      end
      if (push) sb.push_back({m_bit[1:0], m_nom[3:0]});
    end
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (BUSY !== 1'b0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (BUSY !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b want 0", BUSY);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    hit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_nom = 0;
    m_bit = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0]  le_tab [4];
    logic [1:0]  bit_tab [4];
    logic [31:0] pattern;
    int          lows;
    le_tab  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit_tab = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    do_reset();
    check("rst_nom", NOM, 0);
    check("rst_bit", BIT, 0);
    check("rst_le", LE, 4'b0001);
    check("rst_tx", TX, 1);
    check("rst_busy", BUSY, 0);
    check("rst_ovr", OVR, 0);

    // 64 spaced up hits: NOM walk, BIT/LE walk at every wrap
    dir = 1'b1;
    for (int i = 0; i < 64; i++) begin
      do_hit(40, 1);
      check("nom_up", NOM, (i + 1) % 16);
      if (i % 16 == 15) begin
        check("bit_wrap", BIT, bit_tab[i / 16]);
        check("le_wrap", LE, le_tab[i / 16]);
      end
    end
    wait_idle(200);

    // Down count from reset and exact TX waveform
    do_reset();
    dir = 1'b0;
    do_hit(0, 1);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      pattern[k] = TX;
    end
    check("tx_wave_down", pattern, 32'hFFFF_FFF0);
    check("nom_down", NOM, 4'hF);
    check("bit_down", BIT, 2'd3);
    check("le_down", LE, 4'b1000);
    wait_idle(200);
    repeat (2) @(posedge clk);
    #1;
    check("busy_len_single", last_run, 32);

    // Three hits within one frame: pending overwrite, back-to-back frames
    do_reset();
    dir = 1'b1;
    check("ovr_before", OVR, 0);
    do_hit(3, 1);
    do_hit(3, 0);
    do_hit(3, 1);
    check("ovr_set", OVR, 1);
    check("nom_three", NOM, 3);
    wait_idle(200);
    repeat (2) @(posedge clk);
    #1;
    check("busy_len_b2b", last_run, 64);
    check("ovr_sticky", OVR, 1);

    // 70 hits, clr held over 6 hits with a frame in flight, then 4 hits
    for (int i = 0; i < 69; i++) do_hit(40, 1);
    do_hit(8, 1);
    check("busy_at_clr", BUSY, 1);
    clr = 1'b1;
    m_nom = 0;
    m_bit = 0;
    for (int i = 0; i < 6; i++) do_hit(3, 0);
    check("nom_in_clr", NOM, 0);
    check("ovr_cleared", OVR, 0);
    clr = 1'b0;
    wait_idle(200);
    for (int i = 0; i < 4; i++) do_hit(40, 1);
    check("nom_after_clr", NOM, 4);
    check("bit_after_clr", BIT, 0);
    check("ovr_after_clr", OVR, 0);
    wait_idle(200);

    // Reset mid-DATA aborts the frame; hit held across release is ignored
    do_hit(0, 0);
    repeat (8) @(posedge clk);
    #2;
    hit = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", TX, 1);
    check("midrst_busy", BUSY, 0);
    check("midrst_nom", NOM, 0);
    check("midrst_le", LE, 4'b0001);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    m_nom = 0;
    m_bit = 0;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (TX !== 1'b1) lows++;
    end
    check("post_rst_tx_quiet", lows, 0);
    check("post_rst_held_hit", NOM, 0);
    hit = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_hit(40, 1);
    check("post_rst_first", NOM, 1);
    wait_idle(200);
    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
